// File: rtl/golden_nonce_fifo.sv
// Result FIFO behind the hash core: tags golden nonces with the current job and queues them
// for the host. Define GOLDEN_NONCE_DEDUP_EN to drop a push identical to the last accepted entry.
module golden_nonce_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned JOB_W   = 8,
  parameter int unsigned OVF_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       job_load,
  input  logic [JOB_W-1:0]           job_id_in,
  input  logic [NONCE_W-1:0]         golden_nonce,
  input  logic                       golden_nonce_valid,
  output logic [NONCE_W-1:0]         out_nonce,
  output logic [JOB_W-1:0]           out_job,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [OVF_W-1:0]           overflow_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = JOB_W + NONCE_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [JOB_W-1:0] job_q, job_d;

  logic             full, empty, pop, push, take, drop, dup;
  logic [ENT_W-1:0] entry;

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [ENT_W-1:0] last_q, last_d;
  logic             last_vld_q, last_vld_d;
`endif

  always_comb begin
    entry = {job_q, golden_nonce};
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    pop   = !empty && out_ready && !flush;
`ifdef GOLDEN_NONCE_DEDUP_EN
    dup   = last_vld_q && (last_q == entry);
`else
    dup   = 1'b0;
`endif
    // a filtered duplicate is neither stored nor counted as overflow
    take  = golden_nonce_valid && !flush && !dup;
    push  = take && (!full || pop);
    drop  = take && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    ovf_d = (drop && !(&ovf_q)) ? ovf_q + OVF_W'(1) : ovf_q;
    job_d = job_load ? job_id_in : job_q;

`ifdef GOLDEN_NONCE_DEDUP_EN
    last_d     = push ? entry : last_q;
    last_vld_d = flush ? 1'b0 : (push ? 1'b1 : last_vld_q);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      job_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      job_q    <= job_d;
    end
  end

`ifdef GOLDEN_NONCE_DEDUP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  // head is read straight from storage, forced to zero while nothing is held
  always_comb begin
    out_valid    = !empty;
    out_nonce    = out_valid ? mem_q[rd_ptr_q][NONCE_W-1:0] : '0;
    out_job      = out_valid ? mem_q[rd_ptr_q][ENT_W-1:NONCE_W] : '0;
    count        = count_q;
    overflow_cnt = ovf_q;
  end

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Directed plus random bench for golden_nonce_fifo against a queue-based reference model.
module tb_golden_nonce_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        job_load = 1'b0;
  logic [7:0]  job_id_in = '0;
  logic [31:0] golden_nonce = '0;
  logic        gnv = 1'b0;
  logic        out_ready = 1'b0;

  logic [31:0] out_nonce, out_nonce2;
  logic [7:0]  out_job, out_job2;
  logic        out_valid, out_valid2;
  logic [3:0]  count, count2;
  logic [15:0] ovf;
  logic [1:0]  ovf2;

  int checks = 0;
  int errors = 0;

  logic [39:0] q[$];
  logic [7:0]  cur_job;
  int          ov;
  logic [39:0] last;
  bit          lvalid;

  always #5 clk = ~clk;

  golden_nonce_fifo #(.DEPTH(DEPTH), .NONCE_W(32), .JOB_W(8), .OVF_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .job_load(job_load), .job_id_in(job_id_in),
    .golden_nonce(golden_nonce), .golden_nonce_valid(gnv), .out_nonce(out_nonce),
    .out_job(out_job), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .overflow_cnt(ovf)
  );

  golden_nonce_fifo #(.DEPTH(DEPTH), .NONCE_W(32), .JOB_W(8), .OVF_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .flush(flush), .job_load(job_load), .job_id_in(job_id_in),
    .golden_nonce(golden_nonce), .golden_nonce_valid(gnv), .out_nonce(out_nonce2),
    .out_job(out_job2), .out_valid(out_valid2), .out_ready(out_ready), .count(count2),
    .overflow_cnt(ovf2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur_job = '0;
    ov      = 0;
    lvalid  = 1'b0;
    last    = '0;
  endtask

  task automatic check_all();
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("count", 64'(count), 64'(q.size()));
    chk("overflow_cnt", 64'(ovf), 64'(ov > 65535 ? 65535 : ov));
    chk("sat_overflow_cnt", 64'(ovf2), 64'(ov > 3 ? 3 : ov));
    chk("sat_count", 64'(count2), 64'(q.size()));
    if (q.size() != 0) begin
      chk("out_nonce", 64'(out_nonce), 64'(q[0][31:0]));
      chk("out_job", 64'(out_job), 64'(q[0][39:32]));
      chk("sat_out_nonce", 64'(out_nonce2), 64'(q[0][31:0]));
    end
  endtask

  // Samples the inputs, advances one clock, updates the model and checks 1 time unit later.
  task automatic cycle();
    logic        f, jl, g, r, pop, acc, dup;
    logic [7:0]  jid;
    logic [31:0] n;
    f = flush; jl = job_load; g = gnv; r = out_ready; jid = job_id_in; n = golden_nonce;
    @(posedge clk);
    if (reset_n) begin
      pop = (q.size() != 0) && r;
      acc = 1'b0;
      dup = 1'b0;
      if (f) begin
        q.delete();
        lvalid = 1'b0;
      end else begin
        if (g) begin
`ifdef GOLDEN_NONCE_DEDUP_EN
          dup = lvalid && (last == {cur_job, n});
`endif
          if (!dup) begin
            if (q.size() < DEPTH || pop) acc = 1'b1;
            else ov++;
          end
        end
        if (pop) void'(q.pop_front());
        if (acc) begin
          q.push_back({cur_job, n});
          last   = {cur_job, n};
          lvalid = 1'b1;
        end
      end
      if (jl) cur_job = jid;
    end
    #1;
    check_all();
  endtask

  task automatic push(input logic [31:0] n);
    gnv = 1'b1;
    golden_nonce = n;
    cycle();
    gnv = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    chk("reset_out_nonce", 64'(out_nonce), 64'd0);
    chk("reset_out_job", 64'(out_job), 64'd0);
    reset_n = 1'b1;
    cycle();

    // 1: reset in the middle of traffic, then first push after release
    push(32'h1111_0001);
    push(32'h1111_0002);
    reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_ovf", 64'(ovf), 64'd0);
    chk("midreset_out_nonce", 64'(out_nonce), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    push(32'h0e33337a);
    chk("t1_out_nonce", 64'(out_nonce), 64'h0e33337a);
    chk("t1_out_job", 64'(out_job), 64'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // 2: ordering under one job tag
    job_load = 1'b1; job_id_in = 8'h05;
    cycle();
    job_load = 1'b0;
    push(32'h1); push(32'h2); push(32'h3);
    chk("t2_count", 64'(count), 64'd3);
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("t2_pop_nonce", 64'(out_nonce), 64'(i));
      chk("t2_pop_job", 64'(out_job), 64'h05);
      cycle();
    end
    chk("t2_drained", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;

    // 3: overflow, full push+pop, and saturation of the narrow counter
    for (int i = 0; i < 10; i++) push(32'h100 + i);
    chk("t3_count", 64'(count), 64'd8);
    chk("t3_ovf", 64'(ovf), 64'd2);
    chk("t3_head", 64'(out_nonce), 64'h100);
    out_ready = 1'b1;
    push(32'h200);
    out_ready = 1'b0;
    chk("t3_full_pp_count", 64'(count), 64'd8);
    chk("t3_full_pp_ovf", 64'(ovf), 64'd2);
    for (int i = 0; i < 8; i++) push(32'h300 + i);
    chk("t6_sat_ovf", 64'(ovf2), 64'd3);
    chk("t6_wide_ovf", 64'(ovf), 64'd10);

    // 4: job_load racing a push, then flush racing a push
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    job_load = 1'b1; job_id_in = 8'h07;
    push(32'hA);
    job_load = 1'b0;
    chk("t4_old_tag", 64'(out_job), 64'h05);
    flush = 1'b1;
    push(32'hB);
    flush = 1'b0;
    chk("t4_flush_count", 64'(count), 64'd0);
    chk("t4_flush_valid", {63'd0, out_valid}, 64'd0);
    chk("t4_flush_ovf", 64'(ovf), 64'd10);

    // 5: repeated nonce, then same nonce under another job
    job_load = 1'b1; job_id_in = 8'h01;
    cycle();
    job_load = 1'b0;
    push(32'h0e33337a);
    push(32'h0e33337a);
`ifdef GOLDEN_NONCE_DEDUP_EN
    chk("t5_repeat_count", 64'(count), 64'd1);
`else
    chk("t5_repeat_count", 64'(count), 64'd2);
`endif
    job_load = 1'b1; job_id_in = 8'h02;
    cycle();
    job_load = 1'b0;
    push(32'h0e33337a);
`ifdef GOLDEN_NONCE_DEDUP_EN
    chk("t5_newjob_count", 64'(count), 64'd2);
`else
    chk("t5_newjob_count", 64'(count), 64'd3);
`endif

    // random traffic with narrow nonce range so repeats, fills and drains all occur
    for (int i = 0; i < 600; i++) begin
      gnv          = ($urandom % 3) != 0;
      golden_nonce = $urandom % 4;
      out_ready    = ($urandom % 3) == 0;
      flush        = ($urandom % 40) == 0;
      job_load     = ($urandom % 12) == 0;
      job_id_in    = 8'($urandom % 4);
      cycle();
    end
    gnv = 1'b0; flush = 1'b0; job_load = 1'b0; out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
